// File: rtl/floo_vc_credit_scheduler.sv
// floo_vc_credit_scheduler: round-robin VC arbiter with per-VC credit counters driving one physical link.
// Define FLOO_VC_CREDIT_SCHEDULER_OUT_REG_EN to register valid_o/data_o/vc_id_o (1-cycle link latency).
module floo_vc_credit_scheduler #(
   parameter int unsigned NumVirtChannels = 2,
   parameter int unsigned NumCredits = 4,
   parameter type flit_t = logic,
   localparam int unsigned VcIdWidth = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1,
   localparam int unsigned CntWidth = $clog2(NumCredits + 1)
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic  [NumVirtChannels-1:0]                valid_i,
   output logic  [NumVirtChannels-1:0]                ready_o,
   input  flit_t [NumVirtChannels-1:0]                data_i,
   input  logic  [NumVirtChannels-1:0]                credit_i,
   output logic                                       valid_o,
   output flit_t                                      data_o,
   output logic  [VcIdWidth-1:0]                      vc_id_o,
   output logic  [NumVirtChannels-1:0][CntWidth-1:0]  credits_o,
   output logic                                       err_o
);
   logic [NumVirtChannels-1:0][CntWidth-1:0] cnt_q;
   logic [VcIdWidth-1:0] rr_q, gnt_idx;
   logic gnt;
   logic [NumVirtChannels-1:0] sent, ovf;
   logic link_valid;
   flit_t link_data;
   logic [VcIdWidth-1:0] link_vc;
   // Eligibility looks only at registered counts, so credit_i never reaches ready_o.
   always_comb begin
      int unsigned idx;
      idx = 0;
      gnt = 1'b0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < NumVirtChannels; i++) begin
         idx = (32'(rr_q) + i >= NumVirtChannels) ? 32'(rr_q) + i - NumVirtChannels : 32'(rr_q) + i;
         if (!gnt && valid_i[idx] && cnt_q[idx] != '0) begin
            gnt = 1'b1;
            gnt_idx = VcIdWidth'(idx);
         end
      end
   end
   assign ready_o = (gnt && rst_ni) ? NumVirtChannels'(1) << gnt_idx : '0;
   assign sent = valid_i & ready_o;
   assign credits_o = cnt_q;
   always_comb begin
      for (int v = 0; v < NumVirtChannels; v++)
         ovf[v] = credit_i[v] & ~sent[v] & (cnt_q[v] == CntWidth'(NumCredits));
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {NumVirtChannels{CntWidth'(NumCredits)}};
         rr_q <= '0;
         err_o <= 1'b0;
      end else begin
         for (int v = 0; v < NumVirtChannels; v++)
            cnt_q[v] <= ovf[v] ? cnt_q[v] : cnt_q[v] - CntWidth'(sent[v]) + CntWidth'(credit_i[v]);
         if (gnt) rr_q <= (gnt_idx == VcIdWidth'(NumVirtChannels - 1)) ? '0 : gnt_idx + VcIdWidth'(1);
         if (|ovf) err_o <= 1'b1;
      end
   end
   assign link_valid = |sent;
   assign link_data = link_valid ? data_i[gnt_idx] : '0;
   assign link_vc = link_valid ? gnt_idx : '0;
`ifdef FLOO_VC_CREDIT_SCHEDULER_OUT_REG_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         data_o <= '0;
         vc_id_o <= '0;
      end else begin
         valid_o <= link_valid;
         data_o <= link_data;
         vc_id_o <= link_vc;
      end
   end
`else
   assign valid_o = link_valid;
   assign data_o = link_data;
   assign vc_id_o = link_vc;
`endif
endmodule

// File: tb/tb_floo_vc_credit_scheduler.sv
// tb_floo_vc_credit_scheduler: directed scoreboard bench, 2 VCs with 2 credits each.
module tb_floo_vc_credit_scheduler;
   typedef logic [7:0] flit_t;
   typedef struct packed {logic vc; flit_t data;} exp_t;
   logic clk_i = 1'b0, rst_ni = 1'b0;
   logic [1:0] valid_i = '0, credit_i = '0, ready_o;
   flit_t [1:0] data_i = '0;
   logic valid_o, vc_id_o, err_o;
   flit_t data_o;
   logic [1:0][1:0] credits_o;
   int checks = 0, errors = 0;
   logic prev_gnt = 1'b0;
   exp_t sb[$];
   exp_t e;

   always #5 clk_i = ~clk_i;

   floo_vc_credit_scheduler #(.NumVirtChannels(2), .NumCredits(2), .flit_t(flit_t)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .credit_i(credit_i), .valid_o(valid_o), .data_o(data_o), .vc_id_o(vc_id_o),
      .credits_o(credits_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [1:0] c0, input logic [1:0] c1);
      chk({tag, "_credits0"}, 32'(credits_o[0]), 32'(c0));
      chk({tag, "_credits1"}, 32'(credits_o[1]), 32'(c1));
   endtask

   // One link cycle: drive, queue the expected flit, check grant and link valid.
   task automatic cyc(input logic [1:0] v, input logic [1:0] c, input logic [1:0] exp_rdy, input string tag);
      @(posedge clk_i);
      #1;
      valid_i = v;
      credit_i = c;
      data_i = 16'($urandom);
      if (exp_rdy != 2'b00) sb.push_back('{vc: exp_rdy[1], data: data_i[exp_rdy[1]]});
      #2;
      chk({tag, "_ready"}, 32'(ready_o), 32'(exp_rdy));
`ifdef FLOO_VC_CREDIT_SCHEDULER_OUT_REG_EN
      chk({tag, "_valid_o"}, 32'(valid_o), 32'(prev_gnt));
`else
      chk({tag, "_valid_o"}, 32'(valid_o), 32'(|exp_rdy));
`endif
      prev_gnt = |exp_rdy;
   endtask

   always @(negedge clk_i) begin
      if (rst_ni) begin
         for (int v = 0; v < 2; v++) chk("no_underflow", 32'(credits_o[v] <= 2'd2), 32'd1);
         if (valid_o) begin
            chk("flit_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("link_vc_id", 32'(vc_id_o), 32'(e.vc));
               chk("link_data", 32'(data_o), 32'(e.data));
            end
         end
      end
   end

   initial begin
      valid_i = 2'b11;
      #8;
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk_cnt("rst", 2'd2, 2'd2);
      valid_i = 2'b00;
      #1 rst_ni = 1'b1;
      cyc(2'b00, 2'b00, 2'b00, "idle");
      chk_cnt("idle", 2'd2, 2'd2);
      chk("idle_err", 32'(err_o), 32'd0);
      // fairness with credit returned one cycle after each send
      cyc(2'b11, 2'b00, 2'b01, "rr0");
      cyc(2'b11, 2'b01, 2'b10, "rr1");
      cyc(2'b11, 2'b10, 2'b01, "rr2");
      cyc(2'b11, 2'b01, 2'b10, "rr3");
      cyc(2'b00, 2'b10, 2'b00, "rr_end");
      chk_cnt("rr_end", 2'd2, 2'd1);
      cyc(2'b00, 2'b00, 2'b00, "rr_idle");
      chk_cnt("rr_idle", 2'd2, 2'd2);
      // credit exhaustion on VC0
      cyc(2'b01, 2'b00, 2'b01, "ex0");
      cyc(2'b01, 2'b00, 2'b01, "ex1");
      cyc(2'b01, 2'b00, 2'b00, "ex_stall");
      chk_cnt("ex_stall", 2'd0, 2'd2);
      cyc(2'b01, 2'b01, 2'b00, "ex_credit_same_cycle");
      cyc(2'b01, 2'b00, 2'b01, "ex_resend");
      chk_cnt("ex_resend", 2'd1, 2'd2);
      cyc(2'b00, 2'b00, 2'b00, "ex_after");
      chk_cnt("ex_after", 2'd0, 2'd2);
      // simultaneous send and return on VC1
      cyc(2'b10, 2'b00, 2'b10, "sim_pre");
      cyc(2'b10, 2'b10, 2'b10, "sim");
      chk_cnt("sim", 2'd0, 2'd1);
      cyc(2'b00, 2'b00, 2'b00, "sim_after");
      chk_cnt("sim_after", 2'd0, 2'd1);
      cyc(2'b00, 2'b11, 2'b00, "refill0");
      cyc(2'b00, 2'b01, 2'b00, "refill1");
      chk_cnt("refill1", 2'd1, 2'd2);
      cyc(2'b00, 2'b00, 2'b00, "refill2");
      chk_cnt("refill2", 2'd2, 2'd2);
      chk("refill_err", 32'(err_o), 32'd0);
      // overflow on a full VC0
      cyc(2'b00, 2'b01, 2'b00, "ovf");
      chk("ovf_err_before", 32'(err_o), 32'd0);
      cyc(2'b00, 2'b00, 2'b00, "ovf_next");
      chk("ovf_err", 32'(err_o), 32'd1);
      chk_cnt("ovf_next", 2'd2, 2'd2);
      repeat (10) cyc(2'b00, 2'b00, 2'b00, "ovf_hold");
      chk("ovf_err_sticky", 32'(err_o), 32'd1);
      chk_cnt("ovf_hold", 2'd2, 2'd2);
      // arbitration keeps working with the error flag set
      cyc(2'b10, 2'b00, 2'b10, "wrap");
      cyc(2'b11, 2'b00, 2'b01, "post0");
      cyc(2'b11, 2'b00, 2'b10, "post1");
      // reset mid-operation with requests still asserted
      @(negedge clk_i);
      #1 rst_ni = 1'b0;
      sb.delete();
      prev_gnt = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready_o), 32'd0);
      chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
      chk("mid_rst_err", 32'(err_o), 32'd0);
      chk_cnt("mid_rst", 2'd2, 2'd2);
      valid_i = 2'b00;
      #1 rst_ni = 1'b1;
      cyc(2'b11, 2'b00, 2'b01, "after_rst");
      cyc(2'b00, 2'b00, 2'b00, "drain0");
      chk_cnt("drain0", 2'd1, 2'd2);
      cyc(2'b00, 2'b00, 2'b00, "drain1");
      @(negedge clk_i);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/floo_vc_credit_scheduler.md
FLOO_VC_CREDIT_SCHEDULER -- requirements
Module: floo_vc_credit_scheduler

Interface
REQ-001 SHALL have parameter NumVirtChannels, default 2, giving the number of VCs sharing one physical link (minimum 2).
REQ-002 SHALL have parameter NumCredits, default 4, giving the downstream buffer depth per VC, which is also the initial credit count.
REQ-003 SHALL have parameter flit_t, default logic, giving the flit type.
REQ-004 SHALL define derived widths VcIdWidth = max(1, clog2(NumVirtChannels)) and CntWidth = clog2(NumCredits+1).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state is rising-edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port valid_i, input, NumVirtChannels bits: per-VC flit request.
REQ-008 SHALL have port ready_o, output, NumVirtChannels bits: per-VC grant; the flit is consumed when valid_i and ready_o are both high.
REQ-009 SHALL have port data_i, input, NumVirtChannels x flit_t: per-VC flit.
REQ-010 SHALL have port credit_i, input, NumVirtChannels bits: a one-cycle pulse returns one credit for that VC.
REQ-011 SHALL have port valid_o, input-free output, 1 bit: a flit is on the link; the downstream always accepts it and has no ready.
REQ-012 SHALL have port data_o, output, flit_t: the flit on the link.
REQ-013 SHALL have port vc_id_o, output, VcIdWidth bits: the VC index of the flit on data_o.
REQ-014 SHALL have port credits_o, output, NumVirtChannels x CntWidth: the current credit count per VC.
REQ-015 SHALL have port err_o, output, 1 bit: sticky credit-overflow flag.

Function
REQ-016 SHALL treat VC v as eligible when valid_i[v]=1 and cnt[v]>0; a credit_i arriving in the same cycle SHALL NOT make a VC eligible.
REQ-017 SHALL grant at most one eligible VC per cycle, searching round-robin from pointer rr_q upward and wrapping modulo NumVirtChannels.
REQ-018 SHALL assert ready_o[g]=1 only for the granted VC g and drive all other ready_o bits to 0; ready_o SHALL be all 0 when no VC is eligible.
REQ-019 SHALL load rr_q <= (g+1) mod NumVirtChannels on every grant and hold rr_q when there is no grant.
REQ-020 SHALL update each counter as cnt[v] <= cnt[v] - sent[v] + credit_i[v], where sent[v] = valid_i[v] & ready_o[v]; a simultaneous send and return SHALL leave the count unchanged.
REQ-021 SHALL detect overflow when credit_i[v]=1, sent[v]=0 and cnt[v]=NumCredits; in that case cnt[v] SHALL hold NumCredits and err_o SHALL be set on the next cycle and stay set until reset.
REQ-022 SHALL make underflow impossible by construction (REQ-016); the bench SHALL assert cnt[v] never wraps below 0.
REQ-023 SHALL, with the output register disabled, drive valid_o = |sent, data_o = data_i[g] and vc_id_o = g combinationally (0-cycle latency); when idle, data_o and vc_id_o SHALL be 0.
REQ-024 SHALL drive credits_o directly from the counter registers.
REQ-025 SHALL hold ready_o independent of credit_i in the same cycle, so no combinational path runs from credit_i to ready_o.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously set cnt[v]=NumCredits for all v, rr_q=0, err_o=0, valid_o=0, data_o=0, vc_id_o=0 and ready_o=0.
REQ-027 SHALL drop in-flight flits and their credits when reset asserts mid-operation; the downstream is reset together with this block.

Configuration
REQ-028 SHALL, when macro FLOO_VC_CREDIT_SCHEDULER_OUT_REG_EN is defined, register valid_o, data_o and vc_id_o, giving 1-cycle latency from grant to link; the registers SHALL reset to 0 and valid_o SHALL be 0 in any cycle following a no-grant cycle.
REQ-029 SHALL, when FLOO_VC_CREDIT_SCHEDULER_OUT_REG_EN is undefined, drive the outputs per REQ-023; grant, credit and error behaviour SHALL be identical in both builds.

Verification (NumVirtChannels=2, NumCredits=2, macro undefined unless stated)
REQ-030 SHALL check reset: release rst_ni -> credits_o={2,2}, valid_o=0, err_o=0, ready_o=00.
REQ-031 SHALL check fairness: valid_i=11 continuously, with credit_i returned 1 cycle after each send -> vc_id_o sequence 0,1,0,1, no idle cycles.
REQ-032 SHALL check credit exhaustion: only valid_i[0]=1, no credit return -> 2 flits sent, then ready_o[0]=0 and valid_o=0; a credit_i[0] pulse at cycle t -> flit sent at t+1 with credits_o[0]=0 afterward.
REQ-033 SHALL check simultaneous events: cnt[1]=1, send on VC1 and credit_i[1]=1 in the same cycle -> credits_o[1] stays 1.
REQ-034 SHALL check overflow: cnt[0]=2, credit_i[0]=1, no send -> err_o=1 next cycle, credits_o[0]=2, err_o still 1 after 10 cycles.
REQ-035 SHALL check the macro-defined build: valid_i[0]=1 at cycle t -> valid_o=1 and vc_id_o=0 at t+1, ready_o[0]=1 at t.
